// File: rtl/dds_seq_pkg.sv
// Shared types and defaults for the DDS load sequencer: FSM states, default
// widths and the lower bound on the settle gap.
package dds_seq_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LEN_WIDTH  = 16;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int MIN_GAP_CYCLES = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP_F = 3'd1,
        LOAD_F  = 3'd2,
        SETUP_P = 3'd3,
        LOAD_P  = 3'd4,
        GAP     = 3'd5,
        RUN     = 3'd6
    } state_e;

endpackage

// File: rtl/dds_load_sequencer_if.sv
// Retune command channel. A command transfers on a rising edge where
// cmd_valid && cmd_ready; the master holds payload stable while cmd_valid is high.
interface dds_load_sequencer_if
    import dds_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] cmd_freq;
    logic [DATA_WIDTH-1:0] cmd_phase;
    logic [LEN_WIDTH-1:0]  cmd_len;

    modport master (
        output cmd_valid, cmd_freq, cmd_phase, cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_freq, cmd_phase, cmd_len,
        output cmd_ready
    );

endinterface

// File: rtl/dds_run_counter.sv
// Loadable down-counter shared by the settle gap and the run length.
// Loading zero marks the count as infinite: it never decrements or terminates.
module dds_run_counter
    import dds_seq_pkg::*;
#(
    parameter int WIDTH = DEF_LEN_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic             inf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            inf_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
            inf_q <= (load_val_i == '0);
        end else if (dec_i && !inf_q && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Terminal count marks the last cycle of the loaded span.
    assign tc_o = !inf_q && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/dds_load_sequencer.sv
// Host-side DDS driver: loads frequency then phase, waits a settle gap,
// then holds Enable for the commanded run length (0 = continuous).
module dds_load_sequencer
    import dds_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    dds_load_sequencer_if.slave   cmd,
    input  logic                  stop,
    output logic                  Enable,
    output logic                  LoadF,
    output logic                  LoadP,
    output logic [DATA_WIDTH-1:0] FreqPhase,
    output logic                  busy,
    output logic                  done,
    output state_e                dbg_state_o
);

    localparam int GAP_EFF = (GAP_CYCLES < MIN_GAP_CYCLES) ? MIN_GAP_CYCLES : GAP_CYCLES;
    localparam logic [LEN_WIDTH-1:0] GAP_LOAD = LEN_WIDTH'(GAP_EFF);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] phase_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  enable_q;
    logic                  loadf_q;
    logic                  loadp_q;
    logic [DATA_WIDTH-1:0] fp_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  accept;
    logic                  cnt_load;
    logic [LEN_WIDTH-1:0]  cnt_val;
    logic                  cnt_dec;
    logic                  cnt_tc;

    // stop masks ready so that it always beats a simultaneous command.
    assign cmd.cmd_ready = ((state_q == IDLE) || (state_q == RUN)) && !stop;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // Gap count is loaded leaving LOAD_P; run length is loaded leaving GAP.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = len_q;
        cnt_dec  = (state_q == GAP) || (state_q == RUN);
        if (state_q == LOAD_P) begin
            cnt_load = 1'b1;
            cnt_val  = GAP_LOAD;
        end else if ((state_q == GAP) && cnt_tc) begin
            cnt_load = 1'b1;
            cnt_val  = len_q;
        end
    end

    dds_run_counter #(.WIDTH(LEN_WIDTH)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            len_q    <= '0;
            enable_q <= 1'b0;
            loadf_q  <= 1'b0;
            loadp_q  <= 1'b0;
            fp_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            loadf_q <= 1'b0;
            loadp_q <= 1'b0;
            done_q  <= 1'b0;
            if (stop && (state_q != IDLE)) begin
                state_q  <= IDLE;
                enable_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (accept) begin
                state_q  <= SETUP_F;
                fp_q     <= cmd.cmd_freq;
                phase_q  <= cmd.cmd_phase;
                len_q    <= cmd.cmd_len;
                enable_q <= 1'b0;
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    SETUP_F: begin
                        state_q <= LOAD_F;
                        loadf_q <= 1'b1;
                    end
                    LOAD_F: begin
                        state_q <= SETUP_P;
                        fp_q    <= phase_q;
                    end
                    SETUP_P: begin
                        state_q <= LOAD_P;
                        loadp_q <= 1'b1;
                    end
                    LOAD_P: begin
                        state_q <= GAP;
                    end
                    GAP: begin
                        if (cnt_tc) begin
                            state_q  <= RUN;
                            enable_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (cnt_tc) begin
                            state_q  <= IDLE;
                            enable_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Enable      = enable_q;
    assign LoadF       = loadf_q;
    assign LoadP       = loadp_q;
    assign FreqPhase   = fp_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dds_load_sequencer.sv
// Bench for dds_load_sequencer: directed scenarios plus random traffic, checked
// every cycle against a timeline model (cycles elapsed since command acceptance).
module tb_dds_load_sequencer;
  import dds_seq_pkg::*;

  localparam int DW = 16;
  localparam int LW = 16;
  localparam int G  = 2;

  logic          clk;
  logic          rst;
  logic          stop;
  logic          Enable;
  logic          LoadF;
  logic          LoadP;
  logic [DW-1:0] FreqPhase;
  logic          busy;
  logic          done;
  state_e        dbg_state;

  dds_load_sequencer_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) cmd_if ();

  dds_load_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_CYCLES(G)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .stop        (stop),
    .Enable      (Enable),
    .LoadF       (LoadF),
    .LoadP       (LoadP),
    .FreqPhase   (FreqPhase),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  bit            chk_en = 0;
  logic [DW-1:0] exp_q[$];

  // Timeline model: k = edges since acceptance; 1..4 load steps, then G gap
  // cycles, then run; with len>0 the run ends at k == 5+G+len.
  bit            m_active = 0;
  int            m_k = 0;
  int            m_len = 0;
  logic [DW-1:0] m_freq = '0;
  logic [DW-1:0] m_phase = '0;
  logic [DW-1:0] m_fp = '0;
  bit            m_done = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input bit v, input logic [DW-1:0] f, input logic [DW-1:0] p,
                       input logic [LW-1:0] l, input bit s, input bit r);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_freq  = f;
    cmd_if.cmd_phase = p;
    cmd_if.cmd_len   = l;
    stop             = s;
    rst              = r;
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = !stop && (!m_active || (m_k >= 5 + G));
    m_done = 0;
    if (rst) begin
      m_active = 0;
      m_fp     = '0;
    end else if (cmd_if.cmd_valid && rdy) begin
      m_active = 1;
      m_k      = 1;
      m_freq   = cmd_if.cmd_freq;
      m_phase  = cmd_if.cmd_phase;
      m_len    = int'(cmd_if.cmd_len);
      m_fp     = cmd_if.cmd_freq;
    end else if (m_active && stop) begin
      m_active = 0;
    end else if (m_active) begin
      m_k++;
      if (m_k == 2) exp_q.push_back(m_freq);
      if (m_k == 3) m_fp = m_phase;
      if ((m_len != 0) && (m_k == 5 + G + m_len)) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // scoreboard: per-cycle compare against the model
  always @(negedge clk) begin : cmp
    logic [DW-1:0] w;
    if (chk_en) begin
      check("enable",    32'(Enable),    32'(m_active && (m_k >= 5 + G)));
      check("loadf",     32'(LoadF),     32'(m_active && (m_k == 2)));
      check("loadp",     32'(LoadP),     32'(m_active && (m_k == 4)));
      check("freqphase", 32'(FreqPhase), 32'(m_fp));
      check("busy",      32'(busy),      32'(m_active));
      check("done",      32'(done),      32'(m_done));
      check("cmd_ready", 32'(cmd_if.cmd_ready),
            32'(!stop && (!m_active || (m_k >= 5 + G))));
      if (LoadF) begin
        if (exp_q.size() == 0) begin
          check("loadf_unexpected", 32'(LoadF), 32'(0));
        end else begin
          w = exp_q.pop_front();
          check("loadf_word", 32'(FreqPhase), 32'(w));
        end
      end
    end
  end

  initial begin : main
    int en_cnt;
    int done_cnt;
    int lp_cnt;
    int r;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    tick();
    tick();
    chk_en = 1;
    check("rst_enable", 32'(Enable), 32'(0));
    check("rst_fp",     32'(FreqPhase), 32'(0));
    check("rst_busy",   32'(busy), 32'(0));
    check("rst_loads",  32'({LoadF, LoadP, done}), 32'(0));
    check("rst_state",  32'(dbg_state), 32'(IDLE));

    // 1: basic sequence, len=5
    drive(1'b1, 16'h0400, 16'h2000, 16'd5, 1'b0, 1'b0);
    tick();
    check("t1_e0_busy", 32'(busy), 32'(1));
    drive_idle();
    tick();
    check("t1_e1_loadf", 32'(LoadF), 32'(1));
    check("t1_e1_fp", 32'(FreqPhase), 32'h0400);
    tick();
    check("t1_e2_fp", 32'(FreqPhase), 32'h2000);
    tick();
    check("t1_e3_loadp", 32'(LoadP), 32'(1));
    check("t1_e3_fp", 32'(FreqPhase), 32'h2000);
    ticks(2);
    check("t1_e5_enable", 32'(Enable), 32'(0));
    tick();
    check("t1_e6_enable", 32'(Enable), 32'(1));
    en_cnt = 1;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      en_cnt += int'(Enable);
      done_cnt += int'(done);
    end
    check("t1_en_cycles", 32'(en_cnt), 32'(5));
    check("t1_done_cnt", 32'(done_cnt), 32'(1));
    check("t1_busy_end", 32'(busy), 32'(0));

    // 2: continuous run then stop
    drive(1'b1, 16'h1234, 16'h4321, 16'd0, 1'b0, 1'b0);
    tick();
    drive_idle();
    ticks(6);
    en_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      en_cnt += int'(Enable);
      tick();
      done_cnt += int'(done);
    end
    check("t2_en_cycles", 32'(en_cnt), 32'(100));
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    tick();
    drive_idle();
    check("t2_stop_enable", 32'(Enable), 32'(0));
    check("t2_stop_state", 32'(dbg_state), 32'(IDLE));
    check("t2_no_done", 32'(done_cnt + int'(done)), 32'(0));

    // 3: retune while running
    drive(1'b1, 16'h0100, 16'h0200, 16'd0, 1'b0, 1'b0);
    tick();
    drive_idle();
    ticks(9);
    drive(1'b1, 16'h0800, 16'h0000, 16'd7, 1'b0, 1'b0);
    tick();
    drive_idle();
    check("t3_acc_enable", 32'(Enable), 32'(0));
    check("t3_acc_fp", 32'(FreqPhase), 32'h0800);
    tick();
    check("t3_e1_loadf", 32'(LoadF), 32'(1));
    ticks(2);
    check("t3_e3_loadp", 32'(LoadP), 32'(1));
    check("t3_e3_fp", 32'(FreqPhase), 32'h0000);
    ticks(10);
    check("t3_busy_end", 32'(busy), 32'(0));

    // 4: stop during LOAD_F beats a pending command
    drive(1'b1, 16'h5555, 16'hAAAA, 16'd4, 1'b0, 1'b0);
    tick();
    drive_idle();
    tick();
    check("t4_loadf", 32'(LoadF), 32'(1));
    drive(1'b1, 16'h1111, 16'h2222, 16'd4, 1'b1, 1'b0);
    #1;
    check("t4_ready_low", 32'(cmd_if.cmd_ready), 32'(0));
    tick();
    drive_idle();
    check("t4_loadf_off", 32'(LoadF), 32'(0));
    check("t4_busy", 32'(busy), 32'(0));
    lp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      lp_cnt += int'(LoadP);
    end
    check("t4_no_loadp", 32'(lp_cnt), 32'(0));

    // 5: reset in LOAD_P, then a clean command
    drive(1'b1, 16'h0F0F, 16'hF0F0, 16'd3, 1'b0, 1'b0);
    tick();
    drive_idle();
    ticks(3);
    check("t5_loadp", 32'(LoadP), 32'(1));
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    tick();
    check("t5_rst_outs", 32'({Enable, LoadF, LoadP, busy, done}), 32'(0));
    check("t5_rst_fp", 32'(FreqPhase), 32'(0));
    drive(1'b1, 16'h0101, 16'h0202, 16'd2, 1'b0, 1'b0);
    tick();
    drive_idle();
    tick();
    check("t5_loadf", 32'(LoadF), 32'(1));
    check("t5_fp", 32'(FreqPhase), 32'h0101);
    ticks(10);
    check("t5_busy_end", 32'(busy), 32'(0));

    // 6: command on the final counted run cycle wins over done
    drive(1'b1, 16'h3333, 16'h4444, 16'd3, 1'b0, 1'b0);
    tick();
    drive_idle();
    ticks(6);
    check("t6_e6_enable", 32'(Enable), 32'(1));
    ticks(2);
    drive(1'b1, 16'h7777, 16'h8888, 16'd2, 1'b0, 1'b0);
    #1;
    check("t6_ready", 32'(cmd_if.cmd_ready), 32'(1));
    tick();
    drive_idle();
    check("t6_no_done", 32'(done), 32'(0));
    check("t6_state", 32'(dbg_state), 32'(SETUP_F));
    check("t6_fp", 32'(FreqPhase), 32'h7777);
    ticks(10);
    check("t6_busy_end", 32'(busy), 32'(0));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      drive(($urandom_range(0, 3) == 0), DW'($urandom), DW'($urandom),
            LW'($urandom_range(0, 6)), (r >= 2 && r < 7), (r < 2));
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    tick();
    drive_idle();
    ticks(3);
    check("sb_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dds_load_sequencer.md
Name: dds_load_sequencer

Overview:
- Host-side driver for the DDS control port: it generates the Enable, LoadF, LoadP and FreqPhase inputs that the DDS control unit consumes.
- Accepts a retune command (frequency word, phase word, run length) over a valid/ready handshake.
- Sequences the frequency load and then the phase load, waits a settle gap, and runs the generator for the requested number of cycles or continuously.
- Sits between the register/host interface and the DDS top.

Parameters:
- DATA_WIDTH, 16, width of the frequency/phase word and of FreqPhase
- LEN_WIDTH, 16, width of the run-length field
- GAP_CYCLES, 2, idle cycles between the LoadP pulse and Enable rising (min 1); lets the DDS set its internal registers

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_freq  in  DATA_WIDTH  frequency word
- cmd_phase  in  DATA_WIDTH  phase offset word
- cmd_len  in  LEN_WIDTH  run length in Enable-high cycles; 0 = continuous
- stop  in  1  abort / stop request
- Enable  out  1  DDS enable
- LoadF  out  1  one-cycle frequency load strobe
- LoadP  out  1  one-cycle phase load strobe
- FreqPhase  out  DATA_WIDTH  word presented to the DDS
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on natural run-length expiry

Behaviour:
- All outputs are registered except cmd_ready, which is combinational.
- Reset values: Enable=0, LoadF=0, LoadP=0, FreqPhase=0, busy=0, done=0, state=IDLE.
- cmd_ready = (state==IDLE || state==RUN) && !stop.
- The command is latched at acceptance edge E0.
- States and the registered outputs visible after each edge:
  - SETUP_F (after E0): FreqPhase=freq, LoadF=0, Enable=0.
  - LOAD_F (after E1): LoadF=1, FreqPhase=freq.
  - SETUP_P (after E2): FreqPhase=phase, LoadF=0.
  - LOAD_P (after E3): LoadP=1, FreqPhase=phase.
  - GAP (after E4): LoadP=0; stays for GAP_CYCLES cycles.
  - RUN (after E(4+GAP_CYCLES)): Enable=1. With the default GAP_CYCLES, Enable first rises after E6.
- FreqPhase holds the phase word through GAP and RUN, and holds its last value in IDLE.
- RUN with cmd_len=N>0:
  - Enable is high for exactly N cycles.
  - On the edge ending the Nth cycle: return to IDLE, Enable=0, done=1 for one cycle.
- RUN with cmd_len=0: Enable stays high until stop or a new command.
- Retune in RUN: a command accepted in RUN drops Enable on the same edge and enters SETUP_F. The run counter reloads from the new cmd_len.
- Command accepted on the last counted RUN cycle: the command wins; go to SETUP_F, no done pulse.
- stop=1 in any non-IDLE state: next edge goes to IDLE with Enable=0, LoadF=0, LoadP=0 and no done pulse. Because cmd_ready is low while stop=1, stop beats a simultaneous command.
- stop in IDLE: no effect.
- rst mid-sequence: all outputs return to reset values on the next edge, including a LoadF/LoadP strobe in flight. The latched command is discarded.
- LoadF and LoadP are never high together and never high while Enable is high.
- The run counter counts down with no wrap. Counting is inhibited for cmd_len=0.

Decomposition:
- Package dds_seq_pkg: state enum (IDLE, SETUP_F, LOAD_F, SETUP_P, LOAD_P, GAP, RUN), default widths, GAP_CYCLES minimum constant.
- One sub-module, dds_run_counter: loadable down-counter with a zero-means-infinite flag and a terminal-count output. It is reused for both the GAP and RUN countdowns.

Test Plan:
- Reset, then accept freq=0x0400, phase=0x2000, len=5 → LoadF high only after E1 with FreqPhase=0x0400; LoadP high only after E3 with FreqPhase=0x2000; Enable high for exactly 5 cycles starting after E6; done pulses once; busy falls.
- len=0 → Enable stays high for 100 cycles; stop → Enable=0 on the next edge, no done, state IDLE.
- In RUN, accept freq=0x0800, phase=0x0000 → Enable=0 on the acceptance edge; the full LoadF/LoadP sequence reruns with the new words.
- stop asserted while in LOAD_F → LoadF low next edge; LoadP never asserts; cmd_ready=0 during the stop cycle even with cmd_valid=1.
- rst pulsed in the LOAD_P cycle → all outputs at reset values after the next edge; a following command sequences normally.
- Command held valid on the final RUN cycle of len=3 → accepted; no done pulse; SETUP_F follows.
